shifter_operand_stage: RTL and testbench
========================================

# shifter_operand_stage

Registered operand-2 stage for the ARM7TDMI data path, feeding the ALU with the shifted second operand and the shifter carry-out. It drives the existing 32-bit rotator (`barrel_shifter`: rotate amount plus left/right direction) and applies ARM shift semantics around it: masking, sign fill, RRX, the #0/#32 encodings, and register-specified amounts. A valid/ready handshake on both sides allows the ALU to stall it. Register-specified shifts take one extra cycle to read Rs.

## Interface
Parameters: none; width fixed at 32.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `in_valid`  in  1  operand request valid
- `in_ready`  out  1  stage can accept a request
- `is_imm`  in  1  1 = rotated 8-bit immediate form
- `imm8`  in  8  immediate value
- `rot4`  in  4  immediate rotate, right by 2*rot4
- `rm_data`  in  32  Rm value
- `shift_type`  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- `shift_by_reg`  in  1  1 = amount from Rs[7:0]; 0 = amount from `shift_imm`
- `shift_imm`  in  5  immediate shift amount
- `rs_rd`  out  1  Rs read strobe; Rs is valid in the same cycle
- `rs_data`  in  8  Rs[7:0]; sampled only while `rs_rd`=1
- `carry_in`  in  1  current CPSR C flag
- `out_valid`  out  1  result valid
- `out_ready`  in  1  ALU accepts the result
- `op2`  out  32  shifted operand
- `shifter_carry`  out  1  shifter carry-out

## Operation
FSM states:
- IDLE
- RS_READ: entered on accept with `shift_by_reg`=1 and `is_imm`=0. Asserts `rs_rd`. Returns to IDLE after one cycle.

Request fields (Rm, type, C) are latched on accept. `is_imm`=1 overrides `shift_by_reg`.

Immediate form:
- op2 = ROR(imm8, 2*rot4).
- C = `carry_in` if rot4 = 0, else op2[31].

Immediate shift, n = `shift_imm`:
- LSL #0: op2 = Rm, C = cin.
- LSL n: op2 = Rm<<n, C = Rm[32-n].
- LSR #0 means LSR #32: op2 = 0, C = Rm[31]. Otherwise C = Rm[n-1].
- ASR #0 means ASR #32: op2 = 32 copies of Rm[31], C = Rm[31]. Otherwise C = Rm[n-1].
- ROR #0 means RRX: op2 = {cin, Rm[31:1]}, C = Rm[0].

Register shift, n = Rs[7:0] (8-bit amount, 0..255):
- n = 0: op2 = Rm, C = cin, for all types.
- LSL: n = 32 gives op2 = 0, C = Rm[0]. n > 32 gives op2 = 0, C = 0.
- LSR: n = 32 gives op2 = 0, C = Rm[31]. n > 32 gives op2 = 0, C = 0.
- ASR: n >= 32 gives sign fill, C = Rm[31].
- ROR: n[4:0] = 0 gives op2 = Rm, C = Rm[31]. Otherwise rotate by n[4:0], C = Rm[n[4:0]-1].

Logical and arithmetic shifts use rotator output plus a mask/fill derived from amount and direction. No second shifter is allowed.

## Timing
- `in_ready` = (state == IDLE) && (!out_valid || out_ready).
- Accept at edge N:
  - Immediate path: `out_valid` = 1 after edge N, so latency 1.
  - Register path: `rs_rd` = 1 during cycle N..N+1, `rs_data` is sampled at edge N+1, `out_valid` = 1 after N+1, so latency 2.
- `op2` and `shifter_carry` are registered and held stable while `out_valid` && !`out_ready`.
- Simultaneous drain and accept in the same cycle is legal and gives back-to-back throughput of 1/cycle on the immediate path.
- In RS_READ the output register may still hold an undrained result. Transition to IDLE and load of the new result are blocked until the output slot is free, and `rs_rd` stays high until then.
- Reset values: `out_valid` = 0, `op2` = 0, `shifter_carry` = 0, `rs_rd` = 0, state IDLE. Reset mid-operation discards any pending request without emitting it.

## Structure
- Shared package (`arm_pkg`) holds:
  - shift type constants: `SHIFT_LSL`, `SHIFT_LSR`, `SHIFT_ASR`, `SHIFT_ROR`
  - state encoding: `SOP_IDLE`, `SOP_RS_READ`
- One sub-module instance: `barrel_shifter`, with `amt` = effective amount[4:0] and `dir_lr` = 1 for LSL, 0 otherwise.
- Mask, fill and carry-select logic stay local.

## Test plan
- Immediate: imm8 = 0xFF, rot4 = 4, cin = 0 → op2 = 0xFF000000, C = 1, one cycle after accept.
- Immediate shift LSR #0 with Rm = 0x80000001 → op2 = 0, C = 1. ASR #0 with Rm = 0x80000000 → op2 = 0xFFFFFFFF, C = 1. RRX with cin = 1, Rm = 0x3 → op2 = 0x80000001, C = 1.
- Register shift LSL with Rs = 32, Rm = 0x1 → `rs_rd` pulses for one cycle, op2 = 0, C = 1, latency 2. Rs = 33 → op2 = 0, C = 0. Rs = 0 → op2 = Rm, C = cin.
- Register ROR with Rs = 0x40, Rm = 0x80000000 → op2 = 0x80000000, C = 1. Rs = 4, Rm = 0x0000000F → op2 = 0xF0000000, C = 1.
- Backpressure: hold `out_ready` = 0 for 3 cycles with a new request pending → `in_ready` = 0, output stable. Release → result drains, next request accepted in the same cycle, and results stay ordered.
- Assert `rst_n` low during RS_READ → `rs_rd` and `out_valid` go to 0 immediately, and no result appears after reset release.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared ARM data-path definitions: shift encodings, operand-stage FSM states
// and the request fields held across the Rs read cycle.
package arm_pkg;

  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  typedef enum logic {
    SOP_IDLE    = 1'b0,
    SOP_RS_READ = 1'b1
  } sop_state_e;

  // Request fields kept while Rs is being read
  typedef struct packed {
    logic [31:0] rm;
    logic [1:0]  stype;
    logic        cin;
  } sop_req_t;

endpackage

// File: rtl/shifter_operand_stage_if.sv
// Operand-2 stage bus: request side, Rs read port, carry input and result side.
// master = decode/ALU side driving the stage, slave = the stage itself.
interface shifter_operand_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic        is_imm;
  logic [7:0]  imm8;
  logic [3:0]  rot4;
  logic [31:0] rm_data;
  logic [1:0]  shift_type;
  logic        shift_by_reg;
  logic [4:0]  shift_imm;
  logic        rs_rd;
  logic [7:0]  rs_data;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] op2;
  logic        shifter_carry;

  modport master (
    output in_valid, is_imm, imm8, rot4, rm_data, shift_type, shift_by_reg,
           shift_imm, rs_data, carry_in, out_ready,
    input  in_ready, rs_rd, out_valid, op2, shifter_carry
  );

  modport slave (
    input  in_valid, is_imm, imm8, rot4, rm_data, shift_type, shift_by_reg,
           shift_imm, rs_data, carry_in, out_ready,
    output in_ready, rs_rd, out_valid, op2, shifter_carry
  );
endinterface

// File: rtl/barrel_shifter.sv
// 32-bit rotator: rotate din by amt, left when dir_lr=1, right otherwise.
module barrel_shifter (
  input  logic [31:0] din,
  input  logic [4:0]  amt,
  input  logic        dir_lr,
  output logic [31:0] dout
);
  logic [4:0]  ramt;
  logic [63:0] dbl;

  // a left rotate by a equals a right rotate by (32 - a) mod 32
  assign ramt = dir_lr ? 5'(~amt + 5'd1) : amt;
  assign dbl  = {din, din} >> ramt;
  assign dout = dbl[31:0];
endmodule

// File: rtl/shifter_operand_stage.sv
// Registered ARM operand-2 stage: rotated immediates, immediate and
// register-specified shifts built around a single rotator, with a one-deep
// output register and a valid/ready handshake on both sides.
module shifter_operand_stage
  import arm_pkg::*;
(
  input logic                    clk,
  input logic                    rst_n,
  shifter_operand_stage_if.slave bus
);
  sop_state_e  state_q, state_d;
  sop_req_t    req_q;
  logic        out_valid_q, carry_q;
  logic [31:0] op2_q;

  logic        slot_free, accept, go_reg, load;
  logic        use_imm, by_reg, cin;
  logic [31:0] rm;
  logic [1:0]  stype;
  logic [7:0]  n8;
  logic [4:0]  amt;
  logic        dir_lr, big, exact32;
  logic [31:0] rot_in, rot_out, keep_l, keep_r, fill, res;
  logic        res_c;

  assign slot_free = !out_valid_q || bus.out_ready;
  assign accept    = bus.in_valid && bus.in_ready;
  assign go_reg    = !bus.is_imm && bus.shift_by_reg;

  // Operand source: live request while idle, latched request plus Rs while reading Rs
  always_comb begin
    use_imm = bus.is_imm;
    by_reg  = 1'b0;
    rm      = bus.rm_data;
    stype   = bus.shift_type;
    cin     = bus.carry_in;
    n8      = {3'b000, bus.shift_imm};
    if (state_q == SOP_RS_READ) begin
      use_imm = 1'b0;
      by_reg  = 1'b1;
      rm      = req_q.rm;
      stype   = req_q.stype;
      cin     = req_q.cin;
      n8      = bus.rs_data;
    end
  end

  assign amt     = use_imm ? {bus.rot4, 1'b0} : n8[4:0];
  assign dir_lr  = !use_imm && (stype == SHIFT_LSL);
  assign rot_in  = use_imm ? {24'd0, bus.imm8} : rm;
  assign big     = |n8[7:5];
  assign exact32 = (n8 == 8'd32);

  barrel_shifter u_rot (
    .din    (rot_in),
    .amt    (amt),
    .dir_lr (dir_lr),
    .dout   (rot_out)
  );

  // Keep masks: LSL keeps bits at or above amt, right shifts keep the low 32-amt bits
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      keep_l[i] = (6'(i) >= {1'b0, amt});
      keep_r[i] = ((6'(i) + {1'b0, amt}) < 6'd32);
    end
  end

  assign fill = {32{rm[31]}} & ~keep_r;

  // ARM shift semantics on top of the rotator; the carry is taken from the
  // rotated word (bit 0 for LSL, bit 31 for right shifts) for in-range amounts
  always_comb begin
    res   = rot_out;
    res_c = rot_out[31];
    if (use_imm) begin
      res_c = (bus.rot4 == 4'd0) ? cin : rot_out[31];
    end else if (n8 == 8'd0 && (by_reg || stype == SHIFT_LSL)) begin
      res   = rm;
      res_c = cin;
    end else begin
      case (stype)
        SHIFT_LSL:
          if (big) begin
            res   = '0;
            res_c = exact32 & rm[0];
          end else begin
            res   = rot_out & keep_l;
            res_c = rot_out[0];
          end
        SHIFT_LSR:
          if (big || n8 == 8'd0) begin       // #0 encodes LSR #32
            res   = '0;
            res_c = (exact32 || n8 == 8'd0) & rm[31];
          end else begin
            res   = rot_out & keep_r;
          end
        SHIFT_ASR:
          if (big || n8 == 8'd0) begin       // #0 encodes ASR #32
            res   = {32{rm[31]}};
            res_c = rm[31];
          end else begin
            res   = (rot_out & keep_r) | fill;
          end
        default:
          if (n8 == 8'd0) begin              // immediate ROR #0 is RRX
            res   = {cin, rm[31:1]};
            res_c = rm[0];
          end else if (n8[4:0] == 5'd0) begin
            res   = rm;
            res_c = rm[31];
          end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SOP_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: Rs read holds until the output slot can take the result
  always_comb begin
    state_d = state_q;
    case (state_q)
      SOP_IDLE:    if (accept && go_reg) state_d = SOP_RS_READ;
      SOP_RS_READ: if (slot_free)        state_d = SOP_IDLE;
      default:                           state_d = SOP_IDLE;
    endcase
  end

  // FSM outputs: Rs strobe, request ready, result load
  always_comb begin
    bus.rs_rd    = (state_q == SOP_RS_READ);
    bus.in_ready = (state_q == SOP_IDLE) && slot_free;
    load         = (state_q == SOP_RS_READ) ? slot_free : (accept && !go_reg);
  end

  // Latch request fields on accept for use during the Rs read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      req_q <= '0;
    else if (accept) req_q <= '{rm: bus.rm_data, stype: bus.shift_type, cin: bus.carry_in};
  end

  // Output register: load a new result or drain on out_ready, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      op2_q       <= '0;
      carry_q     <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      op2_q       <= res;
      carry_q     <= res_c;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.op2           = op2_q;
  assign bus.shifter_carry = carry_q;
endmodule

// File: tb/tb_shifter_operand_stage.sv
module tb_shifter_operand_stage;
  import arm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shifter_operand_stage_if bus();

  shifter_operand_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] op2;
    logic        c;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  bit   rand_rdy = 1'b0;
  logic        stall_prev = 1'b0;
  logic [32:0] held = '0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model built from wide shifts; returns {carry, op2}
  function automatic logic [32:0] model(logic imm, logic [7:0] i8, logic [3:0] r4,
                                        logic [31:0] rm, logic [1:0] t, logic byreg,
                                        logic [7:0] n, logic cin);
    logic [63:0] y;
    int k;
    if (imm) begin
      y = {24'd0, i8, 24'd0, i8} >> (2 * r4);
      return {(r4 == 4'd0) ? cin : y[31], y[31:0]};
    end
    k = byreg ? int'(n) : int'(n[4:0]);
    if (k == 0) begin
      if (byreg || t == 2'b00) return {cin, rm};
      if (t == 2'b11) return {rm[0], cin, rm[31:1]};
      k = 32;
    end
    case (t)
      2'b00: begin y = {32'd0, rm} << k; return {y[32], y[31:0]}; end
      2'b01: begin y = {rm, 32'd0} >> k; return {y[31], y[63:32]}; end
      2'b10: begin y = $signed({rm, 32'd0}) >>> ((k > 32) ? 32 : k); return {y[31], y[63:32]}; end
      default: begin
        if (k[4:0] == 5'd0) return {rm[31], rm};
        y = {rm, rm} >> k[4:0];
        return {y[31], y[31:0]};
      end
    endcase
  endfunction

  // Drive one request; returns #1 after the accepting edge
  task automatic send(logic imm, logic [7:0] i8, logic [3:0] r4, logic [31:0] rm,
                      logic [1:0] t, logic byreg, logic [4:0] si, logic [7:0] rs, logic cin);
    int cyc;
    logic [32:0] e;
    cyc = 0;
    @(negedge clk);
    while (bus.rs_rd && cyc < 50) begin @(negedge clk); cyc++; end
    bus.is_imm = imm; bus.imm8 = i8; bus.rot4 = r4; bus.rm_data = rm;
    bus.shift_type = t; bus.shift_by_reg = byreg; bus.shift_imm = si;
    bus.rs_data = rs; bus.carry_in = cin; bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && cyc < 50) begin @(negedge clk); #1; cyc++; end
    if (!bus.in_ready) begin
      chk("accept_timeout", bus.in_ready, 1);
      bus.in_valid = 1'b0;
      return;
    end
    e = model(imm, i8, r4, rm, t, byreg, byreg ? rs : {3'b000, si}, cin);
    exp_q.push_back('{op2: e[31:0], c: e[32]});
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin @(negedge clk); cyc++; end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // Scoreboard and hold checker, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) chk("hold", {bus.shifter_carry, bus.op2}, held);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", bus.out_valid, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("op2", bus.op2, mon_e.op2);
          chk("carry", bus.shifter_carry, mon_e.c);
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held       = {bus.shifter_carry, bus.op2};
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #2 bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bus.in_valid = 0; bus.is_imm = 0; bus.imm8 = 0; bus.rot4 = 0; bus.rm_data = 0;
    bus.shift_type = 0; bus.shift_by_reg = 0; bus.shift_imm = 0; bus.rs_data = 0;
    bus.carry_in = 0; bus.out_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_op2", bus.op2, 0);
    chk("rst_carry", bus.shifter_carry, 0);
    chk("rst_rs_rd", bus.rs_rd, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", bus.in_ready, 1);

    // rotated immediate, latency 1
    send(1, 8'hFF, 4'd4, 32'd0, SHIFT_LSL, 0, 5'd0, 8'd0, 0);
    chk("imm_lat1", bus.out_valid, 1);
    // immediate-shift special encodings, back to back
    send(0, 8'd0, 4'd0, 32'h8000_0001, SHIFT_LSR, 0, 5'd0, 8'd0, 0);
    send(0, 8'd0, 4'd0, 32'h8000_0000, SHIFT_ASR, 0, 5'd0, 8'd0, 0);
    send(0, 8'd0, 4'd0, 32'h0000_0003, SHIFT_ROR, 0, 5'd0, 8'd0, 1);
    send(0, 8'd0, 4'd0, 32'h1234_5678, SHIFT_LSL, 0, 5'd0, 8'd0, 1);
    send(0, 8'd0, 4'd0, 32'hC000_0001, SHIFT_LSL, 0, 5'd1, 8'd0, 0);
    send(0, 8'd0, 4'd0, 32'h8000_00F0, SHIFT_ASR, 0, 5'd4, 8'd0, 0);
    send(1, 8'h81, 4'd0, 32'd0, SHIFT_LSL, 0, 5'd0, 8'd0, 1);
    drain();

    // register LSL by 32: one-cycle Rs strobe, latency 2
    send(0, 8'd0, 4'd0, 32'h1, SHIFT_LSL, 1, 5'd0, 8'd32, 0);
    chk("reg_rs_rd", bus.rs_rd, 1);
    chk("reg_not_yet", bus.out_valid, 0);
    @(posedge clk); #1;
    chk("reg_rs_rd_drop", bus.rs_rd, 0);
    chk("reg_lat2", bus.out_valid, 1);
    send(0, 8'd0, 4'd0, 32'h1, SHIFT_LSL, 1, 5'd0, 8'd33, 0);
    send(0, 8'd0, 4'd0, 32'h1234_5678, SHIFT_ASR, 1, 5'd0, 8'd0, 1);
    send(0, 8'd0, 4'd0, 32'h8000_0000, SHIFT_ROR, 1, 5'd0, 8'h40, 0);
    send(0, 8'd0, 4'd0, 32'h0000_000F, SHIFT_ROR, 1, 5'd0, 8'd4, 0);
    send(0, 8'd0, 4'd0, 32'h8000_0000, SHIFT_LSR, 1, 5'd0, 8'd32, 0);
    send(0, 8'd0, 4'd0, 32'h8000_0000, SHIFT_ASR, 1, 5'd0, 8'd200, 0);
    drain();

    // backpressure: result held, next request blocked, then same-cycle drain+accept
    bus.out_ready = 1'b0;
    send(1, 8'h3C, 4'd1, 32'd0, SHIFT_LSL, 0, 5'd0, 8'd0, 0);
    fork
      send(0, 8'd0, 4'd0, 32'h0000_00F0, SHIFT_LSR, 0, 5'd4, 8'd0, 0);
      begin
        repeat (3) begin @(negedge clk); #2 chk("bp_in_ready", bus.in_ready, 0); end
        @(posedge clk); #2 bus.out_ready = 1'b1;
      end
    join
    chk("bp_order_q", exp_q.size(), 1);
    chk("bp_out_valid", bus.out_valid, 1);
    drain();

    // random mix under random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send($urandom_range(0, 3) == 0, 8'($urandom), 4'($urandom), $urandom, 2'($urandom),
           $urandom_range(0, 1) == 1, 5'($urandom),
           ($urandom_range(0, 2) == 0) ? 8'(32 + $urandom_range(0, 2)) : 8'($urandom),
           $urandom_range(0, 1) == 1);
    end
    rand_rdy = 1'b0;
    @(negedge clk); #2 bus.out_ready = 1'b1;
    drain();

    // reset during Rs read discards the request
    send(0, 8'd0, 4'd0, 32'hDEAD_BEEF, SHIFT_LSR, 1, 5'd0, 8'd4, 0);
    chk("rst_mid_rs_rd_pre", bus.rs_rd, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_rs_rd", bus.rs_rd, 0);
    chk("rst_mid_out_valid", bus.out_valid, 0);
    chk("rst_mid_op2", bus.op2, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_result", bus.out_valid, 0);
    chk("rst_idle_ready", bus.in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
